// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scan/debounce/decode into a BCD HHMM entry; define KEYPAD_TIME_CHECK_EN to range-check HHMM on enter
module keypad_entry #(
    parameter int SCAN_DIV       = 250000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [15:0] entry,
    output logic [2:0]  entry_cnt,
    output logic        entry_done,
    output logic        entry_err
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    // nibble {r,c} holds the key at row r, column c
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
    state_t state, state_n;
    logic [3:0] col_m, col_s, pat;
    logic [PW-1:0] pre;
    logic [1:0] r, c, c_sel;
    logic [DW-1:0] db_cnt, rel_cnt;
    logic tick, adv, latch, db_inc, accept, rel_inc, rel_clr;
    logic enter, full, time_ok;
    assign tick  = pre == PW'(SCAN_DIV - 1);
    assign row   = ~(4'b1000 >> r);
    assign c_sel = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
    assign enter = key_valid && key_code == 4'hB;
    assign full  = entry_cnt == 3'd4;
`ifdef KEYPAD_TIME_CHECK_EN
    assign time_ok = entry[15:8] <= 8'h23 && entry[7:4] <= 4'h5;
`else
    assign time_ok = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) state <= SCAN;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        adv     = 1'b0;
        latch   = 1'b0;
        db_inc  = 1'b0;
        accept  = 1'b0;
        rel_inc = 1'b0;
        rel_clr = 1'b0;
        if (tick) begin
            case (state)
                SCAN:
                    if ($onehot(~col_s)) begin
                        latch   = 1'b1;
                        state_n = DEBOUNCE;
                    end else adv = 1'b1;
                DEBOUNCE:
                    if (col_s != pat) begin
                        adv     = 1'b1;
                        state_n = SCAN;
                    end else if (db_cnt == DW'(DEBOUNCE_SCANS - 1)) begin
                        accept  = 1'b1;
                        state_n = HELD;
                    end else db_inc = 1'b1;
                HELD:
                    if (col_s != 4'hF) rel_clr = 1'b1;
                    else if (rel_cnt == DW'(DEBOUNCE_SCANS - 1)) begin
                        rel_clr = 1'b1;
                        state_n = SCAN;
                    end else rel_inc = 1'b1;
                default: state_n = SCAN;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            col_m     <= 4'hF;
            col_s     <= 4'hF;
            pre       <= '0;
            r         <= 2'd0;
            c         <= 2'd0;
            pat       <= 4'hF;
            db_cnt    <= '0;
            rel_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            col_m     <= col;
            col_s     <= col_m;
            pre       <= tick ? '0 : pre + 1'b1;
            r         <= adv ? r + 2'd1 : r;
            c         <= latch ? c_sel : c;
            pat       <= latch ? col_s : pat;
            db_cnt    <= latch ? DW'(1) : db_inc ? db_cnt + 1'b1 : db_cnt;
            rel_cnt   <= rel_clr ? '0 : rel_inc ? rel_cnt + 1'b1 : rel_cnt;
            key_valid <= accept;
            key_code  <= accept ? KEY_MAP[{r, c, 2'b00} +: 4] : key_code;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            entry      <= 16'h0000;
            entry_cnt  <= 3'd0;
            entry_done <= 1'b0;
            entry_err  <= 1'b0;
        end else begin
            entry_done <= enter && full && time_ok;
            entry_err  <= enter && !(full && time_ok);
            if (key_valid && key_code <= 4'd9 && !full) begin
                entry     <= entry_cnt == 3'd0 ? {12'h000, key_code} : {entry[11:0], key_code};
                entry_cnt <= entry_cnt + 3'd1;
            end else if ((key_valid && key_code == 4'hA) || (enter && full && !time_ok)) begin
                entry     <= 16'h0000;
                entry_cnt <= 3'd0;
            end else if (enter && full) entry_cnt <= 3'd0;
        end
    end
endmodule
